// File: rtl/branch_predictor_ctrl_pkg.sv
// Shared types for the branch predictor controller: FSM states and 2-bit counter encodings.
package branch_predictor_ctrl_pkg;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } bp_state_e;

  typedef enum logic [1:0] {
    CtrSnt = 2'd0,
    CtrWnt = 2'd1,
    CtrWt  = 2'd2,
    CtrSt  = 2'd3
  } bp_ctr_e;

  localparam bp_ctr_e CtrReset = CtrWnt;

endpackage

// File: rtl/branch_predictor_ctrl_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module branch_predictor_ctrl_sat_counter
  import branch_predictor_ctrl_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CtrSt) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CtrSnt) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Direction/target predictor with misprediction flush/redirect and saturating perf counters.
// Tables are cleared one entry per cycle after reset before prediction is enabled.
module branch_predictor_ctrl
  import branch_predictor_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] if_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        init_busy,
  output logic [31:0] branch_count,
  output logic [31:0] miss_count
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam int unsigned TagLsb  = INDEX_BITS + 2;
  localparam int unsigned TagMsb  = INDEX_BITS + TAG_BITS + 1;

  logic [1:0]          ctr_q        [Entries];
  logic                btb_valid_q  [Entries];
  logic [TAG_BITS-1:0] btb_tag_q    [Entries];
  logic [31:0]         btb_target_q [Entries];

  bp_state_e             state_q, state_d;
  logic [INDEX_BITS-1:0] clr_idx_q;
  logic [31:0]           branch_count_q, miss_count_q;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic [1:0]            ctr_next;
  logic                  run, hit, miss;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[TagMsb:TagLsb];
  assign ex_tag = ex_pc[TagMsb:TagLsb];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:TagMsb+1], if_pc[1:0], ex_pc[31:TagMsb+1], ex_pc[1:0]};

  branch_predictor_ctrl_sat_counter u_sat_counter (
    .ctr      (ctr_q[ex_idx]),
    .taken    (ex_branch_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == StInit && clr_idx_q == {INDEX_BITS{1'b1}}) state_d = StRun;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StInit;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StInit) clr_idx_q <= clr_idx_q + 1'b1;
    end
  end

  // Gating with reset_n keeps outputs at their reset values while reset is held.
  assign run = reset_n && (state_q == StRun);

  always_comb begin
    hit            = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    predict_taken  = run && hit && ctr_q[if_idx][1];
    predict_target = predict_taken ? btb_target_q[if_idx] : if_pc + 32'd4;
    miss           = ex_branch && ((ex_pred_taken != ex_branch_taken) ||
                                   (ex_branch_taken && (ex_pred_target != ex_branch_target)));
    flush          = run && miss;
    redirect_pc    = flush ? ex_branch_target : 32'd0;
    init_busy      = !run;
  end

  // Tables need no reset of their own; the StInit sweep clears them.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == StInit) begin
        ctr_q[clr_idx_q]       <= CtrReset;
        btb_valid_q[clr_idx_q] <= 1'b0;
      end else if (ex_branch) begin
        ctr_q[ex_idx] <= ctr_next;
        if (ex_branch_taken) begin
          btb_valid_q[ex_idx]  <= 1'b1;
          btb_tag_q[ex_idx]    <= ex_tag;
          btb_target_q[ex_idx] <= ex_branch_target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      branch_count_q <= '0;
      miss_count_q   <= '0;
    end else if (state_q == StRun) begin
      if (ex_branch && branch_count_q != '1) branch_count_q <= branch_count_q + 32'd1;
      if (flush && miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign branch_count = branch_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Randomized and directed bench for branch_predictor_ctrl against a table-level reference model.
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        init_busy;
  logic [31:0] branch_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 16 entries, index pc[5:2], tag pc[13:6].
  int              m_ctr    [16];
  bit              m_valid  [16];
  bit [7:0]        m_tag    [16];
  bit [31:0]       m_target [16];
  longint unsigned m_branches;
  longint unsigned m_misses;

  branch_predictor_ctrl #(
    .INDEX_BITS (4),
    .TAG_BITS   (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .if_pc            (if_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .init_busy        (init_busy),
    .branch_count     (branch_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic bit [7:0] tag_of(input logic [31:0] pc);
    return pc[13:6];
  endfunction

  function automatic logic m_pred_taken(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic m_miss();
    if (!ex_branch) return 1'b0;
    if (ex_pred_taken != ex_branch_taken) return 1'b1;
    return ex_branch_taken && (ex_pred_target != ex_branch_target);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_ctr[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_branches = 0;
    m_misses   = 0;
  endtask

  task automatic drive_ex(input logic b, input logic [31:0] pc, input logic pt,
                          input logic [31:0] ptg, input logic t, input logic [31:0] tg);
    ex_branch        = b;
    ex_pc            = pc;
    ex_pred_taken    = pt;
    ex_pred_target   = ptg;
    ex_branch_taken  = t;
    ex_branch_target = tg;
  endtask

  // Resolve a branch whose pipelined prediction is the model's current prediction.
  task automatic drive_model_pred(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    drive_ex(1'b1, pc, m_pred_taken(pc), m_pred_target(pc), t, tg);
  endtask

  // Advance one clock in run mode, folding the presented EX outcome into the model.
  task automatic step();
    int i;
    if (ex_branch) begin
      if (m_branches < 64'hFFFF_FFFF) m_branches++;
      if (m_miss() && m_misses < 64'hFFFF_FFFF) m_misses++;
      i = idx_of(ex_pc);
      if (ex_branch_taken) begin
        m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(ex_pc);
        m_target[i] = ex_branch_target;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic power_on();
    int n = 0;
    reset_n = 1'b0;
    if_pc   = 32'h0;
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    while (init_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (init_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL power_on_init_done: init_busy=%b after %0d cycles, required 0", init_busy, n);
    end
    m_reset();
  endtask

  task automatic test_random(input int cycles);
    logic [31:0] pc;
    for (int c = 0; c < cycles; c++) begin
      if_pc = {18'h0, 6'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      pc    = {18'h0, 6'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) != 0) begin
        drive_model_pred(pc, 1'($urandom), {24'h0, 6'($urandom_range(0, 3)), 2'b00} + 32'h100);
        if ($urandom_range(0, 4) == 0) ex_pred_taken = 1'($urandom);
      end else begin
        drive_ex(1'b0, pc, 1'($urandom), $urandom, 1'($urandom), $urandom);
      end
      #1;
      n_checks += 6;
      if (predict_taken !== m_pred_taken(if_pc)) begin
        n_fail++;
        $display("FAIL rand_predict_taken pc=%h: got %b expected %b", if_pc, predict_taken,
                 m_pred_taken(if_pc));
      end
      if (predict_target !== m_pred_target(if_pc)) begin
        n_fail++;
        $display("FAIL rand_predict_target pc=%h: got %h expected %h", if_pc, predict_target,
                 m_pred_target(if_pc));
      end
      if (flush !== m_miss()) begin
        n_fail++;
        $display("FAIL rand_flush: got %b expected %b", flush, m_miss());
      end
      if (redirect_pc !== (m_miss() ? ex_branch_target : 32'h0)) begin
        n_fail++;
        $display("FAIL rand_redirect_pc: got %h expected %h", redirect_pc,
                 m_miss() ? ex_branch_target : 32'h0);
      end
      if (branch_count !== 32'(m_branches)) begin
        n_fail++;
        $display("FAIL rand_branch_count: got %0d expected %0d", branch_count, m_branches);
      end
      if (miss_count !== 32'(m_misses)) begin
        n_fail++;
        $display("FAIL rand_miss_count: got %0d expected %0d", miss_count, m_misses);
      end
      step();
    end
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    int n = 0;
    bit flush_seen = 1'b0;
    reset_n = 1'b0;
    if_pc   = 32'h40;
    drive_ex(1'b1, 32'h40, 1'b0, 32'h44, 1'b1, 32'h80);
    #1;
    n_checks += 4;
    if (init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init_busy: got %b expected 1", init_busy);
    end
    if (flush !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_flush: got flush=%b redirect=%h expected 0/0", flush, redirect_pc);
    end
    if (predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_predict_taken: got %b expected 0", predict_taken);
    end
    if (predict_target !== 32'h44) begin
      n_fail++;
      $display("FAIL reset_predict_target: got %h expected 44", predict_target);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (branch_count !== 32'h0 || miss_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", branch_count, miss_count);
    end
    reset_n = 1'b1;
    // EX keeps presenting a mispredicted branch throughout the clear.
    while (n < 40) begin
      #1;
      if (init_busy !== 1'b1) break;
      if (flush !== 1'b0) flush_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    n_checks += 3;
    if (n != 16) begin
      n_fail++;
      $display("FAIL init_busy_cycles: got %0d expected 16", n);
    end
    if (flush_seen) begin
      n_fail++;
      $display("FAIL init_flush: got flush=1 during clear expected 0");
    end
    if (branch_count !== 32'h0) begin
      n_fail++;
      $display("FAIL init_no_count: got %0d expected 0", branch_count);
    end
    m_reset();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if_pc = $urandom & 32'hFFFF_FFFC;
      #1;
      n_checks++;
      if (predict_taken !== 1'b0 || predict_target !== if_pc + 32'd4) begin
        n_fail++;
        $display("FAIL post_init_predict pc=%h: got %b/%h expected 0/%h", if_pc, predict_taken,
                 predict_target, if_pc + 32'd4);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_train();
    if_pc = 32'h40;
    drive_model_pred(32'h40, 1'b1, 32'h80);
    #1;
    n_checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h80) begin
      n_fail++;
      $display("FAIL train_first_miss: got flush=%b redirect=%h expected 1/80", flush, redirect_pc);
    end
    step();
    drive_model_pred(32'h40, 1'b1, 32'h80);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h80) begin
      n_fail++;
      $display("FAIL train_predict: got %b/%h expected 1/80", predict_taken, predict_target);
    end
  endtask

  task automatic test_saturation();
    if_pc = 32'h40;
    repeat (4) begin
      drive_model_pred(32'h40, 1'b1, 32'h80);
      step();
    end
    drive_model_pred(32'h40, 1'b0, 32'h44);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_still_taken: got %b expected 1", predict_taken);
    end
    repeat (2) begin
      drive_model_pred(32'h40, 1'b0, 32'h44);
      step();
    end
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      n_fail++;
      $display("FAIL sat_not_taken: got %b/%h expected 0/44", predict_taken, predict_target);
    end
  endtask

  task automatic test_target_miss();
    if_pc = 32'h40;
    repeat (2) begin
      drive_model_pred(32'h40, 1'b1, 32'h80);
      step();
    end
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h100);
    #1;
    n_checks += 2;
    if (predict_target !== 32'h80) begin
      n_fail++;
      $display("FAIL tmiss_old_target: got %h expected 80", predict_target);
    end
    if (flush !== 1'b1 || redirect_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL tmiss_flush: got flush=%b redirect=%h expected 1/100", flush, redirect_pc);
    end
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h100) begin
      n_fail++;
      $display("FAIL tmiss_new_target: got %b/%h expected 1/100", predict_taken, predict_target);
    end
  endtask

  task automatic test_alias();
    if_pc = 32'h440;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h444) begin
      n_fail++;
      $display("FAIL alias_tag_miss: got %b/%h expected 0/444", predict_taken, predict_target);
    end
    drive_model_pred(32'h40, 1'b0, 32'h44);
    step();
    // Counter now weakly taken; train and read the same entry in one cycle.
    if_pc = 32'h40;
    drive_ex(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #1;
    n_checks += 2;
    if (predict_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL alias_same_cycle_old: got %b expected 1", predict_taken);
    end
    if (flush !== 1'b1 || redirect_pc !== 32'h44) begin
      n_fail++;
      $display("FAIL alias_dir_miss: got flush=%b redirect=%h expected 1/44", flush, redirect_pc);
    end
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL alias_after_update: got %b expected 0", predict_taken);
    end
    drive_model_pred(32'h440, 1'b1, 32'h200);
    step();
    if_pc = 32'h440;
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin
      n_fail++;
      $display("FAIL alias_replace: got %b/%h expected 1/200", predict_taken, predict_target);
    end
    if_pc = 32'h40;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      n_fail++;
      $display("FAIL alias_evicted: got %b/%h expected 0/44", predict_taken, predict_target);
    end
    @(negedge clk);
  endtask

  task automatic test_perf();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks += 2;
    if (branch_count !== 32'(m_branches)) begin
      n_fail++;
      $display("FAIL perf_branch_count: got %0d expected %0d", branch_count, m_branches);
    end
    if (miss_count !== 32'(m_misses)) begin
      n_fail++;
      $display("FAIL perf_miss_count: got %0d expected %0d", miss_count, m_misses);
    end
    force dut.miss_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_count_q;
    m_misses = 64'hFFFF_FFFE;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive_ex(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
      step();
      n_checks++;
      if (miss_count !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL perf_miss_saturate[%0d]: got %h expected ffffffff", k, miss_count);
      end
    end
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    power_on();
    test_random(60);
    test_reset();
    test_train();
    test_saturation();
    test_target_miss();
    test_alias();
    test_perf();
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
